// File: rtl/flight_loop_scheduler_pkg.sv
// Shared types and defaults for the flight-loop scheduler: FSM encodings,
// stage codes, start-pulse payload and small decode helpers.
package flight_loop_scheduler_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int unsigned LOOP_PERIOD_US_DEF   = 2500;
   localparam int unsigned STAGE_TIMEOUT_US_DEF = 200;
   localparam int unsigned OVERRUN_WIDTH_DEF    = 8;

   typedef enum logic [6:0] {
      ST_IDLE      = 7'b000_0001,
      ST_WAIT_TICK = 7'b000_0010,
      ST_ANGLE     = 7'b000_0100,
      ST_RATE      = 7'b000_1000,
      ST_MIX       = 7'b001_0000,
      ST_DONE      = 7'b010_0000,
      ST_FAULT     = 7'b100_0000
   } state_e;

   typedef enum logic [1:0] {
      STAGE_NONE  = 2'd0,
      STAGE_ANGLE = 2'd1,
      STAGE_RATE  = 2'd2,
      STAGE_MIX   = 2'd3
   } stage_e;

   typedef struct packed {
      logic mx;
      logic rc;
      logic ac;
   } start_t;

   // Stage code reported when a given state times out.
   function automatic stage_e stage_of(input state_e s);
      case (s)
         ST_ANGLE: return STAGE_ANGLE;
         ST_RATE:  return STAGE_RATE;
         ST_MIX:   return STAGE_MIX;
         default:  return STAGE_NONE;
      endcase
   endfunction

   function automatic logic is_stage(input state_e s);
      return (s == ST_ANGLE) || (s == ST_RATE) || (s == ST_MIX);
   endfunction

endpackage

// File: rtl/flight_loop_scheduler_tick_timer.sv
// Loop period counter: counts 0..PERIOD-1 while enabled, held at 0 otherwise.
// tick_o is high exactly while the count sits at PERIOD-1.
module loop_tick_timer
   import flight_loop_scheduler_pkg::*;
#(
   parameter int unsigned PERIOD = LOOP_PERIOD_US_DEF
) (
   input  logic us_clk,
   input  logic resetn,
   input  logic enable_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = $clog2(PERIOD);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!enable_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      // Registered decode of the next count keeps tick aligned with count == LAST.
      tick_d = (cnt_d == LAST);
   end

   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         tick_q <= FALSE;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/flight_loop_scheduler.sv
// Sequences angle -> rate -> mixer once per loop period, with a per-stage
// watchdog that drops into safe mode and a saturating overrun counter.
module flight_loop_scheduler
   import flight_loop_scheduler_pkg::*;
#(
   parameter int unsigned LOOP_PERIOD_US   = LOOP_PERIOD_US_DEF,
   parameter int unsigned STAGE_TIMEOUT_US = STAGE_TIMEOUT_US_DEF,
   parameter int unsigned OVERRUN_WIDTH    = OVERRUN_WIDTH_DEF
) (
   input  logic                     us_clk,
   input  logic                     resetn,
   input  logic                     enable,
   input  logic                     ac_complete,
   input  logic                     rc_complete,
   input  logic                     mx_complete,
   output logic                     ac_start,
   output logic                     rc_start,
   output logic                     mx_start,
   output logic                     loop_done,
   output logic                     busy,
   output logic                     safe_mode,
   output logic                     timeout_err,
   output logic [1:0]               failed_stage,
   output logic [OVERRUN_WIDTH-1:0] overrun_count
);

   localparam int unsigned WD_W = $clog2(STAGE_TIMEOUT_US + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(STAGE_TIMEOUT_US - 1);
   localparam logic [OVERRUN_WIDTH-1:0] OVR_MAX = '1;

   state_e                   state_q, state_d;
   start_t                   start_q, start_d;
   logic [WD_W-1:0]          wd_q, wd_d;
   logic [OVERRUN_WIDTH-1:0] ovr_q, ovr_d;
   stage_e                   fstage_q, fstage_d;
   logic                     terr_q, terr_d;
   logic                     done_q, done_d;
   logic                     busy_q, busy_d;
   logic                     safe_q, safe_d;

   logic tick;
   logic in_stage;
   logic first_cycle;
   logic cmpl;
   logic accepted;
   logic wd_expired;

   loop_tick_timer #(
      .PERIOD (LOOP_PERIOD_US)
   ) u_tick_timer (
      .us_clk   (us_clk),
      .resetn   (resetn),
      .enable_i (enable),
      .tick_o   (tick)
   );

   // Completion qualifiers: the start cycle of a stage never accepts a complete.
   always_comb begin
      in_stage    = is_stage(state_q);
      first_cycle = start_q.ac | start_q.rc | start_q.mx;
      cmpl        = ((state_q == ST_ANGLE) && ac_complete) ||
                    ((state_q == ST_RATE)  && rc_complete) ||
                    ((state_q == ST_MIX)   && mx_complete);
      accepted    = in_stage && !first_cycle && cmpl;
      wd_expired  = in_stage && (wd_q >= WD_LAST);
   end

   always_comb begin
      state_d  = state_q;
      start_d  = '0;
      done_d   = FALSE;
      wd_d     = wd_q;
      ovr_d    = ovr_q;
      terr_d   = terr_q;
      fstage_d = fstage_q;

      if (in_stage) begin
         wd_d = wd_q + 1'b1;
         // A tick arriving mid-loop is dropped and only counted.
         if (tick && (ovr_q != OVR_MAX)) begin
            ovr_d = ovr_q + 1'b1;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_WAIT_TICK;
         end
         ST_WAIT_TICK: begin
            if (tick) begin
               state_d    = ST_ANGLE;
               start_d.ac = TRUE;
               wd_d       = '0;
            end
         end
         ST_ANGLE: begin
            if (accepted) begin
               state_d    = ST_RATE;
               start_d.rc = TRUE;
               wd_d       = '0;
            end
         end
         ST_RATE: begin
            if (accepted) begin
               state_d    = ST_MIX;
               start_d.mx = TRUE;
               wd_d       = '0;
            end
         end
         ST_MIX: begin
            if (accepted) begin
               state_d = ST_DONE;
               done_d  = TRUE;
            end
         end
         ST_DONE: begin
            if (tick) begin
               state_d    = ST_ANGLE;
               start_d.ac = TRUE;
               wd_d       = '0;
            end else begin
               state_d = ST_WAIT_TICK;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Complete wins over a coincident timeout.
      if (wd_expired && !accepted) begin
         state_d  = ST_FAULT;
         terr_d   = TRUE;
         fstage_d = stage_of(state_q);
      end

      if (!enable) begin
         state_d = ST_IDLE;
         start_d = '0;
         done_d  = FALSE;
      end

      if (state_d == ST_IDLE) begin
         terr_d   = FALSE;
         fstage_d = STAGE_NONE;
         ovr_d    = '0;
      end

      busy_d = is_stage(state_d);
      safe_d = (state_d == ST_FAULT);
   end

   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         start_q  <= '0;
         wd_q     <= '0;
         ovr_q    <= '0;
         terr_q   <= FALSE;
         fstage_q <= STAGE_NONE;
         done_q   <= FALSE;
         busy_q   <= FALSE;
         safe_q   <= FALSE;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         wd_q     <= wd_d;
         ovr_q    <= ovr_d;
         terr_q   <= terr_d;
         fstage_q <= fstage_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         safe_q   <= safe_d;
      end
   end

   // Starts are gated by enable so an abort silences them in the same cycle.
   assign ac_start      = start_q.ac & enable;
   assign rc_start      = start_q.rc & enable;
   assign mx_start      = start_q.mx & enable;
   assign loop_done     = done_q;
   assign busy          = busy_q;
   assign safe_mode     = safe_q;
   assign timeout_err   = terr_q;
   assign failed_stage  = fstage_q;
   assign overrun_count = ovr_q;

endmodule

// File: tb/tb_flight_loop_scheduler.sv
// Scoreboard bench for flight_loop_scheduler: expected start/done events are
// queued with their cycle numbers and matched as the DUT emits them.
module tb_flight_loop_scheduler;

   localparam int unsigned PERIOD  = 20;
   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned OVW     = 8;

   typedef struct {
      int kind;
      int cyc;
   } evt_t;

   logic           us_clk;
   logic           resetn;
   logic           enable;
   logic           ac_complete, rc_complete, mx_complete;
   logic           ac_start, rc_start, mx_start;
   logic           loop_done, busy, safe_mode, timeout_err;
   logic [1:0]     failed_stage;
   logic [OVW-1:0] overrun_count;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   ac_dly, rc_dly, mx_dly;
   int   ac_cnt = 0, rc_cnt = 0, mx_cnt = 0;
   evt_t exp_q[$];
   evt_t got_e;
   logic [3:0] ev;

   flight_loop_scheduler #(
      .LOOP_PERIOD_US   (PERIOD),
      .STAGE_TIMEOUT_US (TIMEOUT),
      .OVERRUN_WIDTH    (OVW)
   ) dut (
      .us_clk        (us_clk),
      .resetn        (resetn),
      .enable        (enable),
      .ac_complete   (ac_complete),
      .rc_complete   (rc_complete),
      .mx_complete   (mx_complete),
      .ac_start      (ac_start),
      .rc_start      (rc_start),
      .mx_start      (mx_start),
      .loop_done     (loop_done),
      .busy          (busy),
      .safe_mode     (safe_mode),
      .timeout_err   (timeout_err),
      .failed_stage  (failed_stage),
      .overrun_count (overrun_count)
   );

   initial us_clk = 1'b0;
   always #5 us_clk = ~us_clk;

   always @(posedge us_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge us_clk);
   endtask

   function automatic void push(input int kind, input int c);
      evt_t e;
      e.kind = kind;
      e.cyc  = c;
      exp_q.push_back(e);
   endfunction

   function automatic logic [31:0] outs();
      return 32'({ac_start, rc_start, mx_start, loop_done, busy, safe_mode,
                  timeout_err, failed_stage, overrun_count});
   endfunction

   // Stage models: complete fires <dly> cycles after the start pulse (0 = never).
   initial begin
      forever begin
         @(negedge us_clk);
         ac_complete = (ac_cnt == 1);
         rc_complete = (rc_cnt == 1);
         mx_complete = (mx_cnt == 1);
         if (ac_cnt != 0) ac_cnt = ac_cnt - 1;
         if (rc_cnt != 0) rc_cnt = rc_cnt - 1;
         if (mx_cnt != 0) mx_cnt = mx_cnt - 1;
         if (ac_start) ac_cnt = ac_dly;
         if (rc_start) rc_cnt = rc_dly;
         if (mx_start) mx_cnt = mx_dly;
      end
   end

   // Event monitor: kinds 0 ac_start, 1 rc_start, 2 mx_start, 3 loop_done.
   initial begin
      forever begin
         @(negedge us_clk);
         ev = {loop_done, mx_start, rc_start, ac_start};
         if (ev != 4'b0) chk("start_onehot", 32'($countones(ev[2:0]) <= 1), 32'd1);
         for (int k = 0; k < 4; k++) begin
            if (ev[k]) begin
               chk("evt_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  got_e = exp_q.pop_front();
                  chk("evt_kind", 32'(k), 32'(got_e.kind));
                  chk("evt_cycle", 32'(cyc), 32'(got_e.cyc));
               end
            end
         end
      end
   end

   initial begin
      int r, e, a, g, h, b;
      resetn      = 1'b0;
      enable      = 1'b0;
      ac_complete = 1'b0;
      rc_complete = 1'b0;
      mx_complete = 1'b0;
      ac_dly = 3; rc_dly = 3; mx_dly = 3;

      repeat (3) @(negedge us_clk);
      chk("reset_outputs", outs(), 32'd0);

      // Nominal: two loops.
      resetn = 1'b1;
      enable = 1'b1;
      r = cyc;
      push(0, r + 20); push(1, r + 24); push(2, r + 28); push(3, r + 32);
      push(0, r + 40); push(1, r + 44); push(2, r + 48); push(3, r + 52);
      wait_until(r + 21);
      chk("busy_in_angle", 32'(busy), 32'd1);
      wait_until(r + 33);
      chk("busy_wait_tick", 32'(busy), 32'd0);
      wait_until(r + 55);
      chk("overrun_nominal", 32'(overrun_count), 32'd0);

      // Rate stage stalls: watchdog fault.
      rc_dly = 0;
      push(0, r + 60); push(1, r + 64);
      wait_until(r + 71);
      chk("safe_before_to", 32'(safe_mode), 32'd0);
      chk("busy_before_to", 32'(busy), 32'd1);
      wait_until(r + 72);
      chk("safe_mode_fault", 32'(safe_mode), 32'd1);
      chk("timeout_err", 32'(timeout_err), 32'd1);
      chk("failed_stage", 32'(failed_stage), 32'd2);
      chk("busy_fault", 32'(busy), 32'd0);
      wait_until(r + 90);
      chk("fault_held", 32'(safe_mode), 32'd1);
      chk("overrun_in_fault", 32'(overrun_count), 32'd0);
      enable = 1'b0;
      wait_until(r + 91);
      chk("idle_flags", outs(), 32'd0);

      // DONE coincides with tick.
      ac_dly = 5; rc_dly = 5; mx_dly = 6;
      wait_until(r + 93);
      enable = 1'b1;
      e = cyc;
      push(0, e + 20); push(1, e + 26); push(2, e + 32); push(3, e + 39);
      push(0, e + 40);
      wait_until(e + 35);
      ac_dly = 3; rc_dly = 3; mx_dly = 3;
      push(1, e + 44); push(2, e + 48); push(3, e + 52);
      wait_until(e + 41);
      chk("overrun_done_tick", 32'(overrun_count), 32'd0);

      // Long stages: one dropped tick per loop, saturating.
      wait_until(e + 55);
      ac_dly = 7; rc_dly = 7; mx_dly = 7;
      for (int k = 0; k < 300; k++) begin
         b = e + 60 + 40 * k;
         push(0, b); push(1, b + 8); push(2, b + 16); push(3, b + 24);
         wait_until(b + 20);
         chk("overrun_count", 32'(overrun_count), (k + 1 < 255) ? 32'(k + 1) : 32'd255);
      end
      chk("overrun_saturated", 32'(overrun_count), 32'd255);
      chk("timeout_err_clear", 32'(timeout_err), 32'd0);

      // Abort one cycle after ac_start.
      ac_dly = 3; rc_dly = 3; mx_dly = 3;
      a = e + 60 + 40 * 300;
      push(0, a);
      wait_until(a);
      @(posedge us_clk);
      #1 enable = 1'b0;
      wait_until(a + 2);
      chk("busy_abort", 32'(busy), 32'd0);
      wait_until(a + 6);
      chk("idle_after_abort", outs(), 32'd0);

      // Reset during MIX, then restart.
      wait_until(a + 8);
      enable = 1'b1;
      g = cyc;
      push(0, g + 20); push(1, g + 24); push(2, g + 28);
      wait_until(g + 29);
      chk("busy_in_mix", 32'(busy), 32'd1);
      resetn = 1'b0;
      #1;
      chk("async_reset_outputs", outs(), 32'd0);
      wait_until(g + 34);
      resetn = 1'b1;
      h = cyc;
      push(0, h + 20); push(1, h + 24); push(2, h + 28); push(3, h + 32);
      wait_until(h + 35);
      chk("pending_events", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
